dphy_pkt_ctrl: RTL and testbench

DPHY_PKT_CTRL -- requirements
Module: dphy_pkt_ctrl

---
 rtl/csi2_pkg.sv | 25 ++
 rtl/csi2_hdr_ecc.sv | 11 +
 rtl/dphy_pkt_ctrl.sv | 145 ++++++++++++++
 tb/tb_dphy_pkt_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// csi2_pkg: shared state encoding, CSI-2 header field widths and ECC parity masks
package csi2_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_DONE,
    ST_EOT
  } state_t;
  localparam int DT_W  = 8;
  localparam int WC_W  = 16;
  localparam int HDR_W = DT_W + WC_W;
  localparam int ECC_W = 6;
  // Bit i of parity bit P selects header data bit D[i], D = {byte2, byte1, byte0}
  localparam logic [ECC_W-1:0][HDR_W-1:0] ECC_MASK = {
    24'hEFFC00,
    24'hDF03F0,
    24'hB8E38E,
    24'h749A6D,
    24'hF2555B,
    24'hF12CB7
  };
endpackage

// File: rtl/csi2_hdr_ecc.sv
// csi2_hdr_ecc: combinational CSI-2 6-bit Hamming ECC over the 24 header data bits
module csi2_hdr_ecc
  import csi2_pkg::*;
(
  input  logic [HDR_W-1:0] i_data,
  output logic [ECC_W-1:0] o_ecc
);
  for (genvar i = 0; i < ECC_W; i++) begin : g_p
    assign o_ecc[i] = ^(i_data & ECC_MASK[i]);
  end
endmodule

// File: rtl/dphy_pkt_ctrl.sv
// dphy_pkt_ctrl: D-PHY packet framing FSM (sync, header, payload, CRC skip); header ECC check under CSI2_HDR_ECC_EN
module dphy_pkt_ctrl
  import csi2_pkg::*;
#(
  parameter int         SYNC_TIMEOUT = 256,
  parameter logic [7:0] SHORT_DT_MAX = 8'h0F
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hs_active_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  output logic             enable_o,
  output logic             wait_for_sync_o,
  output logic             packet_done_o,
  output logic             hdr_valid_o,
  output logic [DT_W-1:0]  data_id_o,
  output logic [WC_W-1:0]  word_count_o,
  output logic             long_pkt_o,
  output logic             payload_valid_o,
  output logic [7:0]       payload_o,
  output logic             payload_last_o,
  output logic             ecc_err_o,
  output logic             abort_o
);
  localparam int TMO_W = $clog2(SYNC_TIMEOUT + 1);
  state_t           r_state;
  logic [HDR_W-1:0] r_hdr;
  logic [1:0]       r_hdr_cnt;
  logic [WC_W-1:0]  r_rem;
  logic             r_crc_cnt;
  logic [TMO_W-1:0] r_tmo;
  logic             r_done, r_hdr_valid, r_long_pkt, r_pay_valid, r_pay_last, r_ecc_err, r_abort;
  logic [DT_W-1:0]  r_data_id;
  logic [WC_W-1:0]  r_word_count;
  logic [7:0]       r_pay;
  logic             w_long, w_ecc_bad, w_drop;
  logic [WC_W-1:0]  w_wc;
  assign w_wc   = r_hdr[HDR_W-1:DT_W];
  assign w_long = {2'b00, r_hdr[5:0]} > SHORT_DT_MAX;
`ifdef CSI2_HDR_ECC_EN
  logic [ECC_W-1:0] w_ecc;
  csi2_hdr_ecc u_ecc (.i_data(r_hdr), .o_ecc(w_ecc));
  assign w_ecc_bad = w_ecc != byte_i[ECC_W-1:0];
`else
  assign w_ecc_bad = 1'b0;
`endif
  // Early HS exit mid-packet, except when the final CRC byte arrives in the same cycle
  assign w_drop = !hs_active_i && (r_state == ST_SYNC || r_state == ST_HDR || r_state == ST_PAYLOAD ||
                  (r_state == ST_CRC && !(byte_valid_i && r_crc_cnt)));
  assign enable_o        = r_state != ST_IDLE;
  assign wait_for_sync_o = r_state == ST_SYNC;
  assign packet_done_o   = r_done;
  assign hdr_valid_o     = r_hdr_valid;
  assign data_id_o       = r_data_id;
  assign word_count_o    = r_word_count;
  assign long_pkt_o      = r_long_pkt;
  assign payload_valid_o = r_pay_valid;
  assign payload_o       = r_pay;
  assign payload_last_o  = r_pay_last;
  assign ecc_err_o       = r_ecc_err;
  assign abort_o         = r_abort;
  // Packet FSM with registered pulses and header/payload outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_hdr        <= '0;
      r_hdr_cnt    <= '0;
      r_rem        <= '0;
      r_crc_cnt    <= 1'b0;
      r_tmo        <= '0;
      r_done       <= 1'b0;
      r_hdr_valid  <= 1'b0;
      r_data_id    <= '0;
      r_word_count <= '0;
      r_long_pkt   <= 1'b0;
      r_pay_valid  <= 1'b0;
      r_pay        <= '0;
      r_pay_last   <= 1'b0;
      r_ecc_err    <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_pay_valid <= 1'b0;
      r_pay_last  <= 1'b0;
      r_ecc_err   <= 1'b0;
      r_abort     <= 1'b0;
      if (w_drop) begin
        r_abort <= 1'b1;
        r_done  <= 1'b1;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (hs_active_i) begin
            r_tmo   <= '0;
            r_state <= ST_SYNC;
          end
          ST_SYNC: if (byte_valid_i) begin
            r_hdr     <= {byte_i, r_hdr[HDR_W-1:8]};
            r_hdr_cnt <= 2'd1;
            r_state   <= ST_HDR;
          end else if (r_tmo == TMO_W'(SYNC_TIMEOUT - 1)) begin
            r_abort <= 1'b1;
            r_state <= ST_EOT;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
          ST_HDR: if (byte_valid_i) begin
            if (r_hdr_cnt != 2'd3) begin
              r_hdr     <= {byte_i, r_hdr[HDR_W-1:8]};
              r_hdr_cnt <= r_hdr_cnt + 2'd1;
            end else begin
              r_hdr_valid  <= 1'b1;
              r_data_id    <= r_hdr[DT_W-1:0];
              r_word_count <= w_wc;
              r_long_pkt   <= w_long && !w_ecc_bad;
              r_ecc_err    <= w_ecc_bad;
              r_rem        <= w_wc;
              r_crc_cnt    <= 1'b0;
              r_state      <= !(w_long && !w_ecc_bad) ? ST_DONE : (w_wc == '0 ? ST_CRC : ST_PAYLOAD);
            end
          end
          ST_PAYLOAD: if (byte_valid_i) begin
            r_pay_valid <= 1'b1;
            r_pay       <= byte_i;
            r_pay_last  <= r_rem == WC_W'(1);
            r_rem       <= r_rem - WC_W'(1);
            if (r_rem == WC_W'(1)) r_state <= ST_CRC;
          end
          ST_CRC: if (byte_valid_i) begin
            r_crc_cnt <= 1'b1;
            if (r_crc_cnt) r_state <= ST_DONE;
          end
          ST_DONE: begin
            r_done  <= 1'b1;
            r_state <= ST_EOT;
          end
          ST_EOT: if (!hs_active_i) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dphy_pkt_ctrl.sv
// tb_dphy_pkt_ctrl: directed packets with a scoreboard of expected header/payload/end events
module tb_dphy_pkt_ctrl;
  localparam logic [1:0] K_HDR = 2'd0;
  localparam logic [1:0] K_PAY = 2'd1;
  localparam logic [1:0] K_END = 2'd2;
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;
  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        hs_active_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        enable_o, wait_for_sync_o, packet_done_o, hdr_valid_o, long_pkt_o;
  logic        payload_valid_o, payload_last_o, ecc_err_o, abort_o;
  logic [7:0]  data_id_o, payload_o;
  logic [15:0] word_count_o;
  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n;

  dphy_pkt_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .hs_active_i(hs_active_i), .byte_valid_i(byte_valid_i),
    .byte_i(byte_i), .enable_o(enable_o), .wait_for_sync_o(wait_for_sync_o),
    .packet_done_o(packet_done_o), .hdr_valid_o(hdr_valid_o), .data_id_o(data_id_o),
    .word_count_o(word_count_o), .long_pkt_o(long_pkt_o), .payload_valid_o(payload_valid_o),
    .payload_o(payload_o), .payload_last_o(payload_last_o), .ecc_err_o(ecc_err_o),
    .abort_o(abort_o)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm, input logic [1:0] k, input logic [31:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got unexpected output %0h expected nothing", nm, v);
    end else begin
      e = exp_q.pop_front();
      chk(nm, {30'b0, k, v}, {30'b0, e.kind, e.val});
    end
  endtask

  task automatic exp_hdr(input logic ecc, input logic lng, input logic [15:0] wc, input logic [7:0] dt);
    exp_q.push_back('{K_HDR, {14'b0, ecc, lng, wc, dt}});
  endtask

  task automatic exp_pay(input logic last, input logic [7:0] b);
    exp_q.push_back('{K_PAY, {23'b0, last, b}});
  endtask

  task automatic exp_end(input logic done, input logic abort);
    exp_q.push_back('{K_END, {30'b0, done, abort}});
  endtask

  task automatic put(input logic [7:0] b);
    byte_i = b;
    byte_valid_i = 1'b1;
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] dt, input logic [15:0] wc, input logic flip);
    logic [23:0] d;
    d = {wc, dt};
    put(dt);
    put(wc[7:0]);
    put(wc[15:8]);
    put({2'b00, ecc_of(d)} ^ {7'b0, flip});
  endtask

  always @(negedge clk) begin
    if (rst_i) begin
      if (hdr_valid_o) pop_chk("hdr", K_HDR, {14'b0, ecc_err_o, long_pkt_o, word_count_o, data_id_o});
      if (payload_valid_o) pop_chk("payload", K_PAY, {23'b0, payload_last_o, payload_o});
      if (packet_done_o || abort_o) pop_chk("end", K_END, {30'b0, packet_done_o, abort_o});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {enable_o, wait_for_sync_o, packet_done_o, hdr_valid_o, data_id_o, word_count_o,
        long_pkt_o, payload_valid_o, payload_o, payload_last_o, ecc_err_o, abort_o}, 64'd0);
    rst_i = 1'b1;
    @(negedge clk);
    chk("idle_enable", enable_o, 0);
    // Short packet then LP
    hs_active_i = 1'b1;
    @(negedge clk);
    chk("sync_enable", enable_o, 1);
    chk("sync_wait", wait_for_sync_o, 1);
    exp_hdr(0, 0, 16'h1234, 8'h00);
    exp_end(1, 0);
    hdr(8'h00, 16'h1234, 0);
    hs_active_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("short_back_idle", enable_o, 0);
    // Short packet, bytes in EOT ignored
    hs_active_i = 1'b1;
    @(negedge clk);
    exp_hdr(0, 0, 16'h0005, 8'h01);
    exp_end(1, 0);
    hdr(8'h01, 16'h0005, 0);
    repeat (2) @(negedge clk);
    chk("eot_enable", enable_o, 1);
    put(8'h55);
    put(8'h66);
    put(8'h77);
    hs_active_i = 1'b0;
    repeat (3) @(negedge clk);
    // Long packet with stalls, HS drops with the final CRC byte
    hs_active_i = 1'b1;
    @(negedge clk);
    exp_hdr(0, 1, 16'h0004, 8'h2A);
    exp_pay(0, 8'hA1);
    exp_pay(0, 8'hA2);
    exp_pay(0, 8'hA3);
    exp_pay(1, 8'hA4);
    exp_end(1, 0);
    hdr(8'h2A, 16'h0004, 0);
    put(8'hA1);
    put(8'hA2);
    repeat (2) @(negedge clk);
    put(8'hA3);
    put(8'hA4);
    put(8'hC1);
    @(negedge clk);
    hs_active_i = 1'b0;
    put(8'hC2);
    repeat (4) @(negedge clk);
    chk("long_back_idle", enable_o, 0);
    // SYNC timeout
    hs_active_i = 1'b1;
    exp_end(0, 1);
    @(negedge clk);
    n = 1;
    while (!abort_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycle", n, 257);
    @(negedge clk);
    chk("timeout_eot_enable", enable_o, 1);
    chk("timeout_eot_wait", wait_for_sync_o, 0);
    hs_active_i = 1'b0;
    @(negedge clk);
    chk("timeout_idle", enable_o, 0);
    // HS drop after 2 of 4 payload bytes
    hs_active_i = 1'b1;
    @(negedge clk);
    exp_hdr(0, 1, 16'h0004, 8'h2A);
    exp_pay(0, 8'hB1);
    exp_pay(0, 8'hB2);
    exp_end(1, 1);
    hdr(8'h2A, 16'h0004, 0);
    put(8'hB1);
    put(8'hB2);
    hs_active_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("drop_idle", enable_o, 0);
    // Long packet with word count 0
    hs_active_i = 1'b1;
    @(negedge clk);
    exp_hdr(0, 1, 16'h0000, 8'h2A);
    exp_end(1, 0);
    hdr(8'h2A, 16'h0000, 0);
    put(8'hC1);
    put(8'hC2);
    hs_active_i = 1'b0;
    repeat (4) @(negedge clk);
    // Corrupted ECC byte
    hs_active_i = 1'b1;
    @(negedge clk);
`ifdef CSI2_HDR_ECC_EN
    exp_hdr(1, 0, 16'h0004, 8'h2A);
    exp_end(1, 0);
    hdr(8'h2A, 16'h0004, 1);
    put(8'hA1);
    put(8'hA2);
`else
    exp_hdr(0, 1, 16'h0001, 8'h2A);
    exp_pay(1, 8'h5A);
    exp_end(1, 0);
    hdr(8'h2A, 16'h0001, 1);
    put(8'h5A);
    put(8'hC1);
    put(8'hC2);
`endif
    hs_active_i = 1'b0;
    repeat (4) @(negedge clk);
    // Reset mid-packet
    hs_active_i = 1'b1;
    @(negedge clk);
    exp_hdr(0, 1, 16'h0010, 8'h2A);
    exp_pay(0, 8'hD1);
    exp_pay(0, 8'hD2);
    hdr(8'h2A, 16'h0010, 0);
    put(8'hD1);
    put(8'hD2);
    #2;
    rst_i = 1'b0;
    hs_active_i = 1'b0;
    #1;
    chk("rst_data_id", data_id_o, 0);
    chk("rst_word_count", word_count_o, 0);
    chk("rst_enable", enable_o, 0);
    @(negedge clk);
    rst_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
